// File: rtl/arb_pkg.sv
// Shared types and constants for the memory bus arbiter: FSM states,
// grant identifiers and the legal range of the access wait length.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_IO  = 1'b1;

  localparam int WAIT_MIN = 1;
  localparam int WAIT_MAX = 15;
  localparam int CNT_W    = 4;

  // Counter preload: the load edge itself accounts for the first mem_en cycle.
  function automatic logic [CNT_W-1:0] wait_load(input int wait_cycles);
    return CNT_W'(wait_cycles - 1);
  endfunction

endpackage

// File: rtl/arb_wait_counter.sv
// Load/decrement down-counter timing the mem_en window; zero_o flags the
// last cycle of an access.
module arb_wait_counter
  import arb_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q;

  // Load wins over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != {CNT_W{1'b0}})) begin
      cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign zero_o = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between the CPU controller and
// the I/O requester; fixed-length accesses finish with a one-cycle ack.
module mem_bus_arbiter
  import arb_pkg::*;
#(
  parameter int AW   = 8,
  parameter int DW   = 16,
  parameter int WAIT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_cpu,
  input  logic          we_cpu,
  input  logic [AW-1:0] addr_cpu,
  input  logic [DW-1:0] wdata_cpu,
  input  logic          req_io,
  input  logic          we_io,
  input  logic [AW-1:0] addr_io,
  input  logic [DW-1:0] wdata_io,
  output logic          ack_cpu,
  output logic          ack_io,
  output logic [DW-1:0] rdata,
  output logic          grant_cpu,
  output logic          grant_io,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] WAIT_LOAD = wait_load(WAIT);

  state_e        state_q;
  logic          last_grant_q;
  logic          ack_cpu_q, ack_io_q, grant_cpu_q, grant_io_q, busy_q;
  logic          mem_en_q, mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q, rdata_q;

  logic          pick_io_s, start_s, cnt_zero_s;
  logic          we_d;
  logic [AW-1:0] addr_d;
  logic [DW-1:0] wdata_d;

  // Winner selection: a lone requester wins; on a tie the one not served last.
  always_comb begin
    pick_io_s = 1'b0;
    if (req_cpu && req_io) begin
      pick_io_s = (last_grant_q == GNT_CPU);
    end else begin
      pick_io_s = req_io;
    end
    if (pick_io_s) begin
      we_d    = we_io;
      addr_d  = addr_io;
      wdata_d = wdata_io;
    end else begin
      we_d    = we_cpu;
      addr_d  = addr_cpu;
      wdata_d = wdata_cpu;
    end
  end

  assign start_s = (state_q == IDLE) && (req_cpu || req_io);

  arb_wait_counter u_wait_cnt (
    .clk        (clk),
    .reset      (reset),
    .load_i     (start_s),
    .load_val_i (WAIT_LOAD),
    .dec_i      (state_q == ACCESS),
    .zero_o     (cnt_zero_s)
  );

  // Access FSM with all bus-facing outputs registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      last_grant_q <= GNT_IO;
      ack_cpu_q    <= 1'b0;
      ack_io_q     <= 1'b0;
      grant_cpu_q  <= 1'b0;
      grant_io_q   <= 1'b0;
      busy_q       <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= {AW{1'b0}};
      mem_wdata_q  <= {DW{1'b0}};
      rdata_q      <= {DW{1'b0}};
    end else begin
      case (state_q)
        IDLE: begin
          if (start_s) begin
            state_q      <= ACCESS;
            last_grant_q <= pick_io_s ? GNT_IO : GNT_CPU;
            grant_cpu_q  <= !pick_io_s;
            grant_io_q   <= pick_io_s;
            busy_q       <= 1'b1;
            mem_en_q     <= 1'b1;
            mem_we_q     <= we_d;
            mem_addr_q   <= addr_d;
            mem_wdata_q  <= wdata_d;
          end
        end
        ACCESS: begin
          if (cnt_zero_s) begin
            state_q   <= DONE;
            mem_en_q  <= 1'b0;
            mem_we_q  <= 1'b0;
            ack_cpu_q <= grant_cpu_q;
            ack_io_q  <= grant_io_q;
            if (!mem_we_q) begin
              rdata_q <= mem_rdata;
            end
          end
        end
        DONE: begin
          state_q     <= IDLE;
          ack_cpu_q   <= 1'b0;
          ack_io_q    <= 1'b0;
          grant_cpu_q <= 1'b0;
          grant_io_q  <= 1'b0;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= IDLE;
          ack_cpu_q   <= 1'b0;
          ack_io_q    <= 1'b0;
          grant_cpu_q <= 1'b0;
          grant_io_q  <= 1'b0;
          busy_q      <= 1'b0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign ack_cpu   = ack_cpu_q;
  assign ack_io    = ack_io_q;
  assign rdata     = rdata_q;
  assign grant_cpu = grant_cpu_q;
  assign grant_io  = grant_io_q;
  assign busy      = busy_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: a WAIT=2 instance for the main scenarios
// and a WAIT=1 instance for the shortest access.
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;

  logic        req_cpu, we_cpu, req_io, we_io;
  logic [7:0]  addr_cpu, addr_io, mem_addr;
  logic [15:0] wdata_cpu, wdata_io, mem_wdata, mem_rdata, rdata;
  logic        ack_cpu, ack_io, grant_cpu, grant_io, busy, mem_en, mem_we;

  logic        w1_req_cpu, w1_we_cpu, w1_req_io, w1_we_io;
  logic [7:0]  w1_addr_cpu, w1_addr_io, w1_mem_addr;
  logic [15:0] w1_wdata_cpu, w1_wdata_io, w1_mem_wdata, w1_mem_rdata, w1_rdata;
  logic        w1_ack_cpu, w1_ack_io, w1_grant_cpu, w1_grant_io, w1_busy;
  logic        w1_mem_en, w1_mem_we;

  int compared;
  int mismatched;

  mem_bus_arbiter #(.AW(8), .DW(16), .WAIT(2)) u_dut (
    .clk(clk), .reset(reset),
    .req_cpu(req_cpu), .we_cpu(we_cpu), .addr_cpu(addr_cpu), .wdata_cpu(wdata_cpu),
    .req_io(req_io), .we_io(we_io), .addr_io(addr_io), .wdata_io(wdata_io),
    .ack_cpu(ack_cpu), .ack_io(ack_io), .rdata(rdata),
    .grant_cpu(grant_cpu), .grant_io(grant_io), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_bus_arbiter #(.AW(8), .DW(16), .WAIT(1)) u_w1 (
    .clk(clk), .reset(reset),
    .req_cpu(w1_req_cpu), .we_cpu(w1_we_cpu), .addr_cpu(w1_addr_cpu), .wdata_cpu(w1_wdata_cpu),
    .req_io(w1_req_io), .we_io(w1_we_io), .addr_io(w1_addr_io), .wdata_io(w1_wdata_io),
    .ack_cpu(w1_ack_cpu), .ack_io(w1_ack_io), .rdata(w1_rdata),
    .grant_cpu(w1_grant_cpu), .grant_io(w1_grant_io), .busy(w1_busy),
    .mem_en(w1_mem_en), .mem_we(w1_mem_we), .mem_addr(w1_mem_addr), .mem_wdata(w1_mem_wdata),
    .mem_rdata(w1_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ctrl0();
    return {ack_cpu, ack_io, grant_cpu, grant_io, busy, mem_en, mem_we};
  endfunction

  function automatic logic [6:0] ctrl1();
    return {w1_ack_cpu, w1_ack_io, w1_grant_cpu, w1_grant_io, w1_busy, w1_mem_en, w1_mem_we};
  endfunction

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b0;
    req_cpu = 1'b0; we_cpu = 1'b0; addr_cpu = 8'h00; wdata_cpu = 16'h0000;
    req_io  = 1'b0; we_io  = 1'b0; addr_io  = 8'h00; wdata_io  = 16'h0000;
    mem_rdata = 16'h0000;
    w1_req_cpu = 1'b0; w1_we_cpu = 1'b0; w1_addr_cpu = 8'h00; w1_wdata_cpu = 16'h0000;
    w1_req_io  = 1'b0; w1_we_io  = 1'b0; w1_addr_io  = 8'h00; w1_wdata_io  = 16'h0000;
    w1_mem_rdata = 16'h0000;

    // Reset state
    step(); step();
    chk("rst_ctrl", 32'(ctrl0()), 32'h0);
    chk("rst_rdata", 32'(rdata), 32'h0);
    chk("rst_w1_ctrl", 32'(ctrl1()), 32'h0);
    chk("rst_w1_bus", {w1_mem_addr, w1_mem_wdata, 8'h00}, 32'h0);
    chk("rst_w1_rdata", 32'(w1_rdata), 32'h0);
    reset = 1'b1;

    // Warm-up CPU read so rdata is non-zero before the mid-access reset
    req_cpu = 1'b1; addr_cpu = 8'h33; mem_rdata = 16'h5555;
    step(); step(); step();
    chk("warm_ack", 32'(ack_cpu), 32'h1);
    chk("warm_rdata", 32'(rdata), 32'h5555);
    req_cpu = 1'b0;
    step();

    // Reset mid-ACCESS aborts the I/O write immediately
    req_io = 1'b1; we_io = 1'b1; addr_io = 8'h66; wdata_io = 16'hAAAA;
    step();
    chk("mid_grant_io", 32'(grant_io), 32'h1);
    chk("mid_mem_en", 32'(mem_en), 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_ctrl", 32'(ctrl0()), 32'h0);
    chk("abort_bus", {mem_addr, mem_wdata, 8'h00}, 32'h0);
    chk("abort_rdata", 32'(rdata), 32'h0);
    req_io = 1'b0;
    step();
    chk("abort_next_ctrl", 32'(ctrl0()), 32'h0);
    reset = 1'b1;

    // Tie after reset: CPU read 0x12 first, then I/O write 0x40
    req_cpu = 1'b1; we_cpu = 1'b0; addr_cpu = 8'h12;
    req_io  = 1'b1; we_io  = 1'b1; addr_io  = 8'h40; wdata_io = 16'h1234;
    mem_rdata = 16'hBEEF;
    step();
    chk("tie_grant_cpu", 32'(grant_cpu), 32'h1);
    chk("tie_grant_io", 32'(grant_io), 32'h0);
    chk("rd_mem_en1", 32'(mem_en), 32'h1);
    chk("rd_addr", 32'(mem_addr), 32'h12);
    chk("rd_we", 32'(mem_we), 32'h0);
    step();
    chk("rd_mem_en2", 32'(mem_en), 32'h1);
    chk("rd_ack_early", 32'(ack_cpu), 32'h0);
    step();
    chk("rd_ack_cpu", 32'(ack_cpu), 32'h1);
    chk("rd_ack_io", 32'(ack_io), 32'h0);
    chk("rd_rdata", 32'(rdata), 32'hBEEF);
    chk("rd_mem_en_off", 32'(mem_en), 32'h0);
    req_cpu = 1'b0;
    mem_rdata = 16'hDEAD;
    step();
    chk("rd_idle_ctrl", 32'(ctrl0()), 32'h0);
    step();
    chk("wr_grant_io", 32'(grant_io), 32'h1);
    chk("wr_we1", {30'h0, mem_we, mem_en}, 32'h3);
    chk("wr_addr", 32'(mem_addr), 32'h40);
    chk("wr_wdata", 32'(mem_wdata), 32'h1234);
    step();
    chk("wr_we2", {30'h0, mem_we, mem_en}, 32'h3);
    step();
    chk("wr_ack_io", 32'(ack_io), 32'h1);
    chk("wr_ack_cpu", 32'(ack_cpu), 32'h0);
    chk("wr_rdata_kept", 32'(rdata), 32'hBEEF);
    chk("wr_we_off", {30'h0, mem_we, mem_en}, 32'h0);
    req_io = 1'b0;
    step();

    // Both requesting continuously: grants alternate, starting with CPU
    req_cpu = 1'b1; we_cpu = 1'b0; addr_cpu = 8'h80;
    req_io  = 1'b1; we_io  = 1'b0; addr_io  = 8'h90;
    for (int k = 0; k < 6; k++) begin
      mem_rdata = 16'(16'h1000 + k);
      step();
      chk("rr_grant_cpu", 32'(grant_cpu), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_grant_io", 32'(grant_io), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr_addr", 32'(mem_addr), (k % 2 == 0) ? 32'h80 : 32'h90);
      step();
      chk("rr_ack_excl", 32'(ack_cpu & ack_io), 32'h0);
      step();
      chk("rr_ack_cpu", 32'(ack_cpu), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_ack_io", 32'(ack_io), (k % 2 == 1) ? 32'h1 : 32'h0);
      chk("rr_rdata", 32'(rdata), 32'(16'h1000 + k));
      if (k == 5) begin
        req_cpu = 1'b0;
        req_io  = 1'b0;
      end
      step();
      chk("rr_idle", {30'h0, busy, ack_cpu | ack_io}, 32'h0);
    end

    // req_io rises during a CPU access and is served right after it
    req_cpu = 1'b1; we_cpu = 1'b0; addr_cpu = 8'h21; mem_rdata = 16'h0A0A;
    step();
    chk("late_grant_cpu", 32'(grant_cpu), 32'h1);
    req_io = 1'b1; we_io = 1'b1; addr_io = 8'h77; wdata_io = 16'h5A5A;
    step();
    chk("late_no_io", 32'(grant_io), 32'h0);
    chk("late_cpu_addr", 32'(mem_addr), 32'h21);
    step();
    chk("late_ack_cpu", 32'(ack_cpu), 32'h1);
    chk("late_rdata", 32'(rdata), 32'h0A0A);
    req_cpu = 1'b0;
    step();
    chk("late_idle", 32'(grant_io), 32'h0);
    step();
    chk("late_grant_io", 32'(grant_io), 32'h1);
    chk("late_io_addr", 32'(mem_addr), 32'h77);
    chk("late_io_wdata", 32'(mem_wdata), 32'h5A5A);
    chk("late_io_we", 32'(mem_we), 32'h1);
    addr_io = 8'h99; wdata_io = 16'h0000; req_io = 1'b0;
    step();
    chk("held_addr", 32'(mem_addr), 32'h77);
    chk("held_wdata", 32'(mem_wdata), 32'h5A5A);
    chk("held_en", 32'(mem_en), 32'h1);
    step();
    chk("held_ack_io", 32'(ack_io), 32'h1);
    chk("held_rdata", 32'(rdata), 32'h0A0A);
    step();
    chk("held_idle", 32'(busy), 32'h0);

    // WAIT=1 instance: back-to-back CPU reads, ack every third cycle
    w1_req_cpu = 1'b1; w1_we_cpu = 1'b0; w1_addr_cpu = 8'h05;
    for (int k = 0; k < 3; k++) begin
      w1_mem_rdata = 16'(16'hC000 + k);
      step();
      chk("w1_en", 32'(w1_mem_en), 32'h1);
      chk("w1_grant", {30'h0, w1_grant_cpu, w1_busy}, 32'h3);
      chk("w1_addr", 32'(w1_mem_addr), 32'h05);
      step();
      chk("w1_ack", 32'(w1_ack_cpu), 32'h1);
      chk("w1_en_off", 32'(w1_mem_en), 32'h0);
      chk("w1_rdata", 32'(w1_rdata), 32'(16'hC000 + k));
      if (k == 2) begin
        w1_req_cpu = 1'b0;
      end
      step();
      chk("w1_idle", 32'(ctrl1()), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
